int8_dot_accum_seq: RTL and testbench

- Sequential dot-product engine. Accepts a stream of signed int8 operand pairs over a valid/ready handshake.
- Accumulates the products into a 16-bit register through one internal int8_mac_pp_feedback instance (combinational MAC, 16-bit wrapping result). The accumulator register feeds back as the MAC's accumulator input.
- Returns the final dot product on a valid/ready result port.
- Sits between operand-fetch logic and the result writeback buffer.

---
 rtl/int8_dot_accum_seq.sv | 120 ++++++++++++
 tb/tb_int8_dot_accum_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int8_dot_accum_seq.sv
// Sequential int8 dot-product engine: streams operand pairs into a 16-bit wrapping accumulator.
// Optional sticky signed-overflow flag on port ovf when INT8_DOT_ACCUM_OVF_EN is defined.

module int8_mac_pp_feedback (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   input  logic [15:0] i_acc,
   output logic [15:0] o_sum
);
   logic signed [15:0] w_prod;

   assign w_prod = $signed({{8{i_a[7]}}, i_a}) * $signed({{8{i_b[7]}}, i_b});
   assign o_sum  = w_prod + i_acc;
endmodule

// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting operand pairs until len_q beats seen
// DONE   | result presented, waiting for out_ready
module int8_dot_accum_seq #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
`ifdef INT8_DOT_ACCUM_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_acc;
   logic [15:0]      r_out;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_len_q;
   logic [15:0]      w_mac_sum;
   logic             w_beat;
   logic             w_last;
   logic             w_start_ok;

   int8_mac_pp_feedback u_mac (
      .i_a   (in_a),
      .i_b   (in_b),
      .i_acc (r_acc),
      .o_sum (w_mac_sum)
   );

   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_beat     = in_valid && in_ready;
   assign w_last     = w_beat && (r_cnt == (r_len_q - LEN_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
         S_ACCUM: if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_ACCUM);
      out_valid = (r_state == S_DONE);
      busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
      out_data  = r_out;
   end

   // r_out is a separate copy so the presented result stays put after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
         r_len_q <= '0;
      end else if (w_start_ok) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_len_q <= len;
         if (len == '0) r_out <= '0;
      end else if (w_beat) begin
         r_acc <= w_mac_sum;
         r_cnt <= r_cnt + LEN_W'(1);
         if (w_last) r_out <= w_mac_sum;
      end
   end

`ifdef INT8_DOT_ACCUM_OVF_EN
   logic        r_ovf;
   logic [15:0] w_prod;

   assign w_prod = $signed({{8{in_a[7]}}, in_a}) * $signed({{8{in_b[7]}}, in_b});
   assign ovf    = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf <= 1'b0;
      else if (w_start_ok)
         r_ovf <= 1'b0;
      else if (w_beat && (r_acc[15] == w_prod[15]) && (w_mac_sum[15] != r_acc[15]))
         r_ovf <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_int8_dot_accum_seq.sv
// Self-checking bench for int8_dot_accum_seq: directed scenarios plus random vectors vs. an arithmetic model.
// Define INT8_DOT_ACCUM_OVF_EN to also check the ovf flag.

module tb_int8_dot_accum_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;
`ifdef INT8_DOT_ACCUM_OVF_EN
   logic        ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   int8_dot_accum_seq #(.LEN_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef INT8_DOT_ACCUM_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   // Reference: signed sum of products folded to 16 bits; overflow when exact add leaves int16 range.
   int ref_acc;
   bit ref_ovf;

   task automatic ref_clear();
      ref_acc = 0;
      ref_ovf = 1'b0;
   endtask

   task automatic ref_add(input logic [7:0] a, input logic [7:0] b);
      int exact;
      exact = ref_acc + int'($signed(a)) * int'($signed(b));
      if (exact > 32767 || exact < -32768) ref_ovf = 1'b1;
      ref_acc = int'(shortint'(exact));
   endtask

   // Drives one vector with all-valid beats from the given arrays; leaves the DUT in DONE.
   task automatic run_vector(input int n, input logic [7:0] av[$], input logic [7:0] bv[$]);
      @(negedge clk);
      start = 1'b1; len = 8'(n);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_a = av[i]; in_b = bv[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b data=%h, want 0 0 0 0000",
                  in_ready, out_valid, busy, out_data);
      end
`ifdef INT8_DOT_ACCUM_OVF_EN
      n_checks++;
      if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] av[$] = '{8'd2, 8'hFC, 8'd127};
      logic [7:0] bv[$] = '{8'd3, 8'd5, 8'd127};
      run_vector(3, av, bv);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3EF3 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL basic: got vld=%b data=%h rdy=%b, want 1 3ef3 0", out_valid, out_data, in_ready);
      end
`ifdef INT8_DOT_ACCUM_OVF_EN
      n_checks++;
      if (ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h3EF3) begin
         n_errors++;
         $display("FAIL basic_release: got vld=%b busy=%b data=%h, want 0 0 3ef3", out_valid, busy, out_data);
      end
   endtask

   task automatic test_empty();
      @(negedge clk);
      start = 1'b1; len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL empty: got vld=%b data=%h rdy=%b busy=%b, want 1 0000 0 1",
                  out_valid, out_data, in_ready, busy);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL empty_release: got vld=%b busy=%b, want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] av[$] = '{8'h80, 8'h80, 8'h80};
      run_vector(3, av, av);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hC000) begin
         n_errors++;
         $display("FAIL wrap: got vld=%b data=%h, want 1 c000", out_valid, out_data);
      end
`ifdef INT8_DOT_ACCUM_OVF_EN
      n_checks++;
      if (ovf !== 1'b1) begin n_errors++; $display("FAIL wrap_ovf: got %b want 1", ovf); end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_bubbles_backpressure();
      logic       vpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] apat[4] = '{8'd5, 8'd99, 8'd99, 8'd7};
      logic [7:0] bpat[4] = '{8'hFA, 8'd99, 8'd99, 8'd7};
      @(negedge clk);
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL bubble_ready[%0d]: got %b want 1", i, in_ready);
         end
         in_valid = vpat[i]; in_a = apat[i]; in_b = bpat[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len = 8'd5;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'd19 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure[%0d]: got vld=%b data=%h rdy=%b, want 1 0013 0",
                     i, out_valid, out_data, in_ready);
         end
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL backpressure_release: got vld=%b busy=%b rdy=%b, want 0 0 0",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] av[$] = '{8'd3};
      @(negedge clk);
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_a = 8'd50; in_b = 8'd60;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid: got vld=%b busy=%b rdy=%b, want 0 0 0", out_valid, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_vector(1, av, av);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd9) begin
         n_errors++;
         $display("FAIL reset_mid_next: got vld=%b data=%h, want 1 0009", out_valid, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int v = 0; v < 200; v++) begin
         int n, idx, cyc, hold;
         n = $urandom_range(20, 1);
         ref_clear();
         @(negedge clk);
         start = 1'b1; len = 8'(n);
         @(negedge clk);
         start = 1'b0;
         idx = 0; cyc = 0;
         while (idx < n && cyc < 200) begin
            in_valid = ($urandom_range(3, 0) != 0);
            in_a = 8'($urandom); in_b = 8'($urandom);
            if (in_valid && in_ready) begin
               ref_add(in_a, in_b);
               idx++;
            end
            @(negedge clk);
            cyc++;
         end
         in_valid = 1'b0;
         hold = $urandom_range(2, 0);
         for (int h = 0; h <= hold; h++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(ref_acc)) begin
               n_errors++;
               $display("FAIL random[%0d] len=%0d: got vld=%b data=%h, want 1 %h",
                        v, n, out_valid, out_data, 16'(ref_acc));
            end
`ifdef INT8_DOT_ACCUM_OVF_EN
            n_checks++;
            if (ovf !== ref_ovf) begin
               n_errors++; $display("FAIL random_ovf[%0d]: got %b want %b", v, ovf, ref_ovf);
            end
`endif
            if (h == hold) out_ready = 1'b1;
            @(negedge clk);
         end
         out_ready = 1'b0;
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL random_release[%0d]: got vld=%b busy=%b, want 0 0", v, out_valid, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_wrap();
      test_bubbles_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
